// File: rtl/sync_filter_bus.sv
// -----------------------------------------------------------------------------
// sync_filter_bus
//
// Brings a bus of independent asynchronous status lines (PHY / OOB / link pins)
// into the clk domain. Each bit goes through its own multi-flop synchroniser,
// then a stability filter: a new level is only accepted once the synchronised
// value has disagreed with the current output for C_FILT_CNT consecutive
// cycles. Every accepted change produces a one-cycle rise or fall pulse.
//
// Bits are fully independent; no coherency is implied between them. Bits that
// change together may resolve in different cycles.
//
// Parameters
//   C_WIDTH     number of independent input bits (1..32)
//   C_STAGES    synchroniser flops per bit (>=2)
//   C_FILT_CNT  consecutive stable synced cycles to accept a new level
//               (>=1; 1 disables filtering)
//   C_RST_VAL   reset value of the synchroniser flops and of sync_out
//
// Ports
//   clk         sole clock
//   rst         synchronous reset, active high
//   async_in    asynchronous inputs, any timing
//   sync_out    filtered, synchronised level
//   rise_pulse  one-cycle pulse per bit when sync_out goes 0->1
//   fall_pulse  one-cycle pulse per bit when sync_out goes 1->0
//   changed     OR of all rise/fall pulses, same cycle
//   glitch_clr  clears glitch_cnt on the next edge (wins over an increment)
//   glitch_cnt  saturating count of cycles in which at least one bit rejected
//               a glitch
//
// Build option
//   SYNC_FILTER_GLITCH_CNT_EN  when defined, the glitch counter is built.
//   When undefined, glitch_cnt is tied to 8'h00 and glitch_clr is ignored;
//   both ports stay present so the interface does not change.
// -----------------------------------------------------------------------------
module sync_filter_bus #(
  parameter int                 C_WIDTH    = 4,
  parameter int                 C_STAGES   = 2,
  parameter int                 C_FILT_CNT = 4,
  parameter logic [C_WIDTH-1:0] C_RST_VAL  = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [C_WIDTH-1:0] async_in,
  output logic [C_WIDTH-1:0] sync_out,
  output logic [C_WIDTH-1:0] rise_pulse,
  output logic [C_WIDTH-1:0] fall_pulse,
  output logic               changed,
  input  logic               glitch_clr,
  output logic [7:0]         glitch_cnt
);

  // Counter only ever needs to reach C_FILT_CNT-1; one spare code keeps the
  // width well-defined for C_FILT_CNT=1.
  localparam int              CNT_W    = $clog2(C_FILT_CNT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(C_FILT_CNT - 1);

  // ---------------------------------------------------------------------------
  // Stage p0: synchroniser chain (index 0 samples the pin)
  // ---------------------------------------------------------------------------
  (* ASYNC_REG = "TRUE" *) logic [C_WIDTH-1:0] syncChain_p0 [C_STAGES];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < C_STAGES; k++) begin
        syncChain_p0[k] <= C_RST_VAL;
      end
    end else begin
      syncChain_p0[0] <= async_in;
      for (int k = 1; k < C_STAGES; k++) begin
        syncChain_p0[k] <= syncChain_p0[k-1];
      end
    end
  end

  logic [C_WIDTH-1:0] syncLvl;
  assign syncLvl = syncChain_p0[C_STAGES-1];

  // ---------------------------------------------------------------------------
  // Stage p1: per-bit stability filter and edge pulses
  // ---------------------------------------------------------------------------
  logic [C_WIDTH-1:0][CNT_W-1:0] filtCnt_p1;
  logic [C_WIDTH-1:0][CNT_W-1:0] cntNext;
  logic [C_WIDTH-1:0]            level_p1;
  logic [C_WIDTH-1:0]            levelNext;
  logic [C_WIDTH-1:0]            risePulse_p1;
  logic [C_WIDTH-1:0]            fallPulse_p1;
  logic                          changed_p1;
  logic [C_WIDTH-1:0]            riseNext;
  logic [C_WIDTH-1:0]            fallNext;
  logic [C_WIDTH-1:0]            rejectBits;

  // The counter tracks how many consecutive cycles the synced value has
  // disagreed with the accepted level. Returning to the accepted level with a
  // non-zero count means a transition was seen but not held long enough.
  always_comb begin
    cntNext    = filtCnt_p1;
    levelNext  = level_p1;
    riseNext   = '0;
    fallNext   = '0;
    rejectBits = '0;
    for (int i = 0; i < C_WIDTH; i++) begin
      if (syncLvl[i] == level_p1[i]) begin
        cntNext[i]    = '0;
        rejectBits[i] = (filtCnt_p1[i] != '0);
      end else if (filtCnt_p1[i] == CNT_LAST) begin
        cntNext[i]   = '0;
        levelNext[i] = syncLvl[i];
        riseNext[i]  = syncLvl[i];
        fallNext[i]  = ~syncLvl[i];
      end else begin
        cntNext[i] = filtCnt_p1[i] + CNT_W'(1);
      end
    end
  end

  // Pulses are registered together with the level so they line up with the
  // cycle in which sync_out changes.
  always_ff @(posedge clk) begin
    if (rst) begin
      filtCnt_p1   <= '0;
      level_p1     <= C_RST_VAL;
      risePulse_p1 <= '0;
      fallPulse_p1 <= '0;
      changed_p1   <= 1'b0;
    end else begin
      filtCnt_p1   <= cntNext;
      level_p1     <= levelNext;
      risePulse_p1 <= riseNext;
      fallPulse_p1 <= fallNext;
      changed_p1   <= |(riseNext | fallNext);
    end
  end

  assign sync_out   = level_p1;
  assign rise_pulse = risePulse_p1;
  assign fall_pulse = fallPulse_p1;
  assign changed    = changed_p1;

  // ---------------------------------------------------------------------------
  // Stage p1: glitch statistics
  // ---------------------------------------------------------------------------
`ifdef SYNC_FILTER_GLITCH_CNT_EN
  function automatic logic [7:0] satInc8(input logic [7:0] val);
    return (val == 8'hFF) ? val : val + 8'd1;
  endfunction

  logic [7:0] glitchCnt_p1;

  // One increment per cycle regardless of how many bits rejected at once.
  always_ff @(posedge clk) begin
    if (rst) begin
      glitchCnt_p1 <= 8'h00;
    end else if (glitch_clr) begin
      glitchCnt_p1 <= 8'h00;
    end else if (|rejectBits) begin
      glitchCnt_p1 <= satInc8(glitchCnt_p1);
    end
  end

  assign glitch_cnt = glitchCnt_p1;
`else
  logic unusedGlitch;
  assign unusedGlitch = glitch_clr ^ (|rejectBits);
  assign glitch_cnt   = 8'h00;
`endif

endmodule

// File: tb/tb_sync_filter_bus.sv
module tb_sync_filter_bus;

  localparam int              W  = 4;
  localparam int              ST = 2;
  localparam int              F  = 4;
  localparam logic [W-1:0]    RV = '0;

`ifdef SYNC_FILTER_GLITCH_CNT_EN
  localparam logic [7:0] GC_ONE = 8'd1;
  localparam logic [7:0] GC_SAT = 8'd255;
`else
  localparam logic [7:0] GC_ONE = 8'd0;
  localparam logic [7:0] GC_SAT = 8'd0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         glitch_clr = 1'b0;
  logic [W-1:0] async_in = '0;
  logic [W-1:0] sync_out, rise_pulse, fall_pulse;
  logic         changed;
  logic [7:0]   glitch_cnt;

  int vecCnt = 0;
  int errCnt = 0;

  always #5 clk = ~clk;

  sync_filter_bus #(
    .C_WIDTH   (W),
    .C_STAGES  (ST),
    .C_FILT_CNT(F),
    .C_RST_VAL (RV)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .async_in  (async_in),
    .sync_out  (sync_out),
    .rise_pulse(rise_pulse),
    .fall_pulse(fall_pulse),
    .changed   (changed),
    .glitch_clr(glitch_clr),
    .glitch_cnt(glitch_cnt)
  );

  // Reference model. The pin reaches the filter ST edges after it is sampled.
  // A bit takes the opposite level once the last F synced samples (since
  // reset) all show that opposite level. A glitch is a cycle where the synced
  // value equals the output but the previous synced sample did not.
  logic [W-1:0] mDly [ST];
  logic [W-1:0] mHist [$];
  logic [W-1:0] mOut  = RV;
  logic [W-1:0] mRise = '0;
  logic [W-1:0] mFall = '0;
  logic         mChg  = 1'b0;
  logic [7:0]   mGlitch = 8'd0;

  always @(posedge clk) begin
    logic [W-1:0] sv, nOut;
    logic anyG, allOpp;
    if (rst) begin
      for (int k = 0; k < ST; k++) mDly[k] = RV;
      mHist.delete();
      mOut = RV; mRise = '0; mFall = '0; mChg = 1'b0; mGlitch = 8'd0;
    end else begin
      sv = mDly[ST-1];
      mHist.push_back(sv);
      if (mHist.size() > F) void'(mHist.pop_front());
      nOut = mOut;
      anyG = 1'b0;
      for (int b = 0; b < W; b++) begin
        allOpp = (mHist.size() == F);
        foreach (mHist[j]) if (mHist[j][b] == mOut[b]) allOpp = 1'b0;
        if (allOpp) nOut[b] = ~mOut[b];
        if (sv[b] == mOut[b] && mHist.size() >= 2 && mHist[mHist.size()-2][b] != mOut[b])
          anyG = 1'b1;
      end
`ifdef SYNC_FILTER_GLITCH_CNT_EN
      if (glitch_clr) mGlitch = 8'd0;
      else if (anyG && mGlitch != 8'd255) mGlitch = mGlitch + 8'd1;
`else
      mGlitch = 8'd0;
`endif
      mRise = nOut & ~mOut;
      mFall = ~nOut & mOut;
      mChg  = |(mRise | mFall);
      mOut  = nOut;
      for (int k = ST-1; k > 0; k--) mDly[k] = mDly[k-1];
      mDly[0] = async_in;
    end
  end

  task automatic test_reset();
    rst = 1'b1; async_in = 4'hF; glitch_clr = 1'b0;
    repeat (3) begin
      @(negedge clk);
      vecCnt++;
      if ({sync_out, rise_pulse, fall_pulse, changed, glitch_cnt} !== 21'h0) begin
        errCnt++;
        $display("FAIL reset_state out=%h r=%h f=%h c=%b g=%0d want all zero",
                 sync_out, rise_pulse, fall_pulse, changed, glitch_cnt);
      end
    end
    rst = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      vecCnt++;
      if ({sync_out, rise_pulse, fall_pulse, changed, glitch_cnt} !== {mOut, mRise, mFall, mChg, mGlitch}) begin
        errCnt++;
        $display("FAIL reset_model k=%0d got out=%h r=%h f=%h c=%b g=%0d want out=%h r=%h f=%h c=%b g=%0d",
                 k, sync_out, rise_pulse, fall_pulse, changed, glitch_cnt, mOut, mRise, mFall, mChg, mGlitch);
      end
      vecCnt++;
      if ((k <= 5 && (sync_out !== 4'h0 || changed !== 1'b0)) ||
          (k == 6 && (sync_out !== 4'hF || rise_pulse !== 4'hF || changed !== 1'b1)) ||
          (k >= 7 && (sync_out !== 4'hF || rise_pulse !== 4'h0))) begin
        errCnt++;
        $display("FAIL reset_release edge=%0d got out=%h r=%h c=%b", k, sync_out, rise_pulse, changed);
      end
    end
  endtask

  task automatic test_single_rise();
    async_in = 4'h0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      vecCnt++;
      if ({sync_out, rise_pulse, fall_pulse, changed, glitch_cnt} !== {mOut, mRise, mFall, mChg, mGlitch}) begin
        errCnt++;
        $display("FAIL settle_model k=%0d got out=%h r=%h f=%h c=%b g=%0d want out=%h r=%h f=%h c=%b g=%0d",
                 k, sync_out, rise_pulse, fall_pulse, changed, glitch_cnt, mOut, mRise, mFall, mChg, mGlitch);
      end
    end
    async_in = 4'h1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      vecCnt++;
      if ({sync_out, rise_pulse, fall_pulse, changed, glitch_cnt} !== {mOut, mRise, mFall, mChg, mGlitch}) begin
        errCnt++;
        $display("FAIL rise_model k=%0d got out=%h r=%h f=%h c=%b g=%0d want out=%h r=%h f=%h c=%b g=%0d",
                 k, sync_out, rise_pulse, fall_pulse, changed, glitch_cnt, mOut, mRise, mFall, mChg, mGlitch);
      end
      vecCnt++;
      if ((k <= 5 && sync_out !== 4'h0) ||
          (k == 6 && (sync_out !== 4'h1 || rise_pulse !== 4'h1 || changed !== 1'b1)) ||
          (k >= 7 && (sync_out !== 4'h1 || rise_pulse !== 4'h0 || changed !== 1'b0))) begin
        errCnt++;
        $display("FAIL bit0_rise edge=%0d got out=%h r=%h c=%b", k, sync_out, rise_pulse, changed);
      end
    end
  endtask

  task automatic test_glitch_reject();
    logic seenRise;
    seenRise = 1'b0;
    glitch_clr = 1'b1;
    @(negedge clk);
    glitch_clr = 1'b0;
    async_in = 4'h3;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 3) async_in = 4'h1;
      if (rise_pulse[1] === 1'b1) seenRise = 1'b1;
      vecCnt++;
      if ({sync_out, rise_pulse, fall_pulse, changed, glitch_cnt} !== {mOut, mRise, mFall, mChg, mGlitch}) begin
        errCnt++;
        $display("FAIL glitch_model k=%0d got out=%h r=%h f=%h c=%b g=%0d want out=%h r=%h f=%h c=%b g=%0d",
                 k, sync_out, rise_pulse, fall_pulse, changed, glitch_cnt, mOut, mRise, mFall, mChg, mGlitch);
      end
    end
    vecCnt++;
    if (sync_out !== 4'h1 || seenRise !== 1'b0 || glitch_cnt !== GC_ONE) begin
      errCnt++;
      $display("FAIL glitch_reject got out=%h riseSeen=%b g=%0d want out=1 riseSeen=0 g=%0d",
               sync_out, seenRise, glitch_cnt, GC_ONE);
    end
  endtask

  task automatic test_saturation();
    for (int n = 0; n < 300; n++) begin
      for (int c = 0; c < 6; c++) begin
        async_in = (c < 2) ? 4'h3 : 4'h1;
        @(negedge clk);
        vecCnt++;
        if ({sync_out, rise_pulse, fall_pulse, changed, glitch_cnt} !== {mOut, mRise, mFall, mChg, mGlitch}) begin
          errCnt++;
          $display("FAIL sat_model n=%0d got out=%h r=%h f=%h c=%b g=%0d want out=%h r=%h f=%h c=%b g=%0d",
                   n, sync_out, rise_pulse, fall_pulse, changed, glitch_cnt, mOut, mRise, mFall, mChg, mGlitch);
        end
      end
    end
    repeat (2) @(negedge clk);
    vecCnt++;
    if (glitch_cnt !== GC_SAT) begin
      errCnt++;
      $display("FAIL glitch_saturate got %0d want %0d", glitch_cnt, GC_SAT);
    end
    glitch_clr = 1'b1;
    @(negedge clk);
    glitch_clr = 1'b0;
    vecCnt++;
    if (glitch_cnt !== 8'd0) begin
      errCnt++;
      $display("FAIL glitch_clear got %0d want 0", glitch_cnt);
    end
    // One ordinary glitch, then one whose rejection edge coincides with clr.
    for (int rep = 0; rep < 2; rep++) begin
      async_in = 4'h3;
      @(negedge clk);
      @(negedge clk);
      async_in = 4'h1;
      @(negedge clk);
      @(negedge clk);
      glitch_clr = (rep == 1);
      @(negedge clk);
      glitch_clr = 1'b0;
      vecCnt++;
      if (glitch_cnt !== ((rep == 1) ? 8'd0 : GC_ONE) || glitch_cnt !== mGlitch) begin
        errCnt++;
        $display("FAIL glitch_clr_coincident rep=%0d got %0d want %0d", rep, glitch_cnt,
                 (rep == 1) ? 8'd0 : GC_ONE);
      end
      repeat (2) @(negedge clk);
    end
  endtask

  task automatic test_simultaneous();
    logic seen;
    seen = 1'b0;
    async_in = 4'hC;
    repeat (8) @(negedge clk);
    vecCnt++;
    if (sync_out !== 4'hC) begin
      errCnt++;
      $display("FAIL simul_setup got out=%h want c", sync_out);
    end
    async_in = 4'h9;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      vecCnt++;
      if ({sync_out, rise_pulse, fall_pulse, changed, glitch_cnt} !== {mOut, mRise, mFall, mChg, mGlitch}) begin
        errCnt++;
        $display("FAIL simul_model k=%0d got out=%h r=%h f=%h c=%b g=%0d want out=%h r=%h f=%h c=%b g=%0d",
                 k, sync_out, rise_pulse, fall_pulse, changed, glitch_cnt, mOut, mRise, mFall, mChg, mGlitch);
      end
      if (changed === 1'b1 && !seen) begin
        seen = 1'b1;
        vecCnt++;
        if (k != 6 || fall_pulse !== 4'h4 || rise_pulse !== 4'h1 || sync_out !== 4'h9) begin
          errCnt++;
          $display("FAIL simul_pulses edge=%0d got r=%h f=%h out=%h want edge=6 r=1 f=4 out=9",
                   k, rise_pulse, fall_pulse, sync_out);
        end
      end
    end
    vecCnt++;
    if (!seen) begin
      errCnt++;
      $display("FAIL simul_timeout got changed never want changed within 10 edges");
    end
  endtask

  task automatic test_rst_mid_filter();
    async_in = 4'h0;
    repeat (8) @(negedge clk);
    async_in = 4'h1;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    vecCnt++;
    if (sync_out !== 4'h0 || rise_pulse !== 4'h0 || changed !== 1'b0) begin
      errCnt++;
      $display("FAIL rst_mid_filter got out=%h r=%h c=%b want 0 0 0", sync_out, rise_pulse, changed);
    end
    rst = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      vecCnt++;
      if ({sync_out, rise_pulse, fall_pulse, changed, glitch_cnt} !== {mOut, mRise, mFall, mChg, mGlitch}) begin
        errCnt++;
        $display("FAIL requal_model k=%0d got out=%h r=%h f=%h c=%b g=%0d want out=%h r=%h f=%h c=%b g=%0d",
                 k, sync_out, rise_pulse, fall_pulse, changed, glitch_cnt, mOut, mRise, mFall, mChg, mGlitch);
      end
      vecCnt++;
      if ((k <= 5 && (sync_out !== 4'h0 || rise_pulse !== 4'h0)) ||
          (k == 6 && (sync_out !== 4'h1 || rise_pulse !== 4'h1))) begin
        errCnt++;
        $display("FAIL requalify edge=%0d got out=%h r=%h", k, sync_out, rise_pulse);
      end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 3000; k++) begin
      for (int b = 0; b < W; b++)
        if ($urandom_range(0, 5) == 0) async_in[b] = ~async_in[b];
      glitch_clr = ($urandom_range(0, 19) == 0);
      rst        = ($urandom_range(0, 199) == 0);
      @(negedge clk);
      vecCnt++;
      if ({sync_out, rise_pulse, fall_pulse, changed, glitch_cnt} !== {mOut, mRise, mFall, mChg, mGlitch}) begin
        errCnt++;
        $display("FAIL random_model k=%0d got out=%h r=%h f=%h c=%b g=%0d want out=%h r=%h f=%h c=%b g=%0d",
                 k, sync_out, rise_pulse, fall_pulse, changed, glitch_cnt, mOut, mRise, mFall, mChg, mGlitch);
      end
    end
    rst = 1'b0;
    glitch_clr = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_rise();
    test_glitch_reject();
    test_saturation();
    test_simultaneous();
    test_rst_mid_filter();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecCnt, errCnt);
    $finish;
  end

endmodule
